loop_scan_sequencer: RTL and testbench



---
 rtl/loop_scan_sequencer_pkg.sv | 44 ++++
 rtl/loop_scan_sequencer.sv | 135 +++++++++++++
 tb/tb_loop_scan_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/loop_scan_sequencer_pkg.sv
// Shared definitions for the BeeF loop-bracket scan sequencer: opcodes,
// PC step requests, scan FSM states and a bracket-role helper.
package loop_scan_sequencer_pkg;

    localparam int PC_WIDTH_DEFAULT    = 16;
    localparam int DEPTH_WIDTH_DEFAULT = 8;

    typedef enum logic [3:0] {
        NOP = 4'd0,
        INC = 4'd1,
        DEC = 4'd2,
        MVR = 4'd3,
        MVL = 4'd4,
        OUT = 4'd5,
        INP = 4'd6,
        LPO = 4'd7,
        LPC = 4'd8,
        HLT = 4'd9
    } op_code;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_FWD  = 2'd1,
        STEP_BWD  = 2'd2
    } PC_STEP;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        STEP  = 3'd1,
        WAIT  = 3'd2,
        MATCH = 3'd3,
        ERR   = 3'd4
    } SCAN_STATE;

    // Bracket that nests deeper in the given scan direction (0 fwd, 1 bwd).
    function automatic op_code opener_of(input logic dir);
        return dir ? LPC : LPO;
    endfunction

    function automatic op_code closer_of(input logic dir);
        return dir ? LPO : LPC;
    endfunction

endpackage

// File: rtl/loop_scan_sequencer.sv
// Steps the PC across a loop body to the matching bracket, stalling the
// control unit meanwhile and tracking nesting depth.
//
// state | meaning
// IDLE  | watching for a taken '[' (cell zero) or ']' (cell nonzero)
// STEP  | boundary check, then request one PC step in scan direction
// WAIT  | wait for the opcode at the stepped PC and classify it
// MATCH | matching bracket found; final forward step past it
// ERR   | unmatched bracket or depth overflow; held until reset
module loop_scan_sequencer
    import loop_scan_sequencer_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEFAULT,
    parameter int DEPTH_WIDTH = DEPTH_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  op_code                 instruction,
    input  logic                   instr_valid,
    input  logic                   cell_zero,
    input  logic [PC_WIDTH-1:0]    pc,
    output PC_STEP                 pc_step,
    output logic                   stalling,
    output logic                   scan_dir,
    output logic [DEPTH_WIDTH-1:0] depth,
    output logic                   scan_done,
    output logic                   scan_error
);

    SCAN_STATE              state, state_nxt;
    PC_STEP                 pc_step_nxt;
    logic                   stalling_nxt;
    logic                   scan_dir_nxt;
    logic [DEPTH_WIDTH-1:0] depth_nxt;
    logic                   scan_done_nxt;
    logic                   scan_error_nxt;

    logic fwd_trigger, bwd_trigger, at_limit, fetch_ready;

    // scan_done high means we are in the cycle right after MATCH: the opcode
    // on the bus is still the matched bracket, so it must not re-trigger.
    assign fwd_trigger = instr_valid && !scan_done && (instruction == LPO) && cell_zero;
    assign bwd_trigger = instr_valid && !scan_done && (instruction == LPC) && !cell_zero;
    assign at_limit    = scan_dir ? (pc == '0) : (pc == '1);
    // While a step is still visible the PC has not moved yet; ignore the bus.
    assign fetch_ready = instr_valid && (pc_step == STEP_NONE);

    always_comb begin
        state_nxt      = state;
        pc_step_nxt    = STEP_NONE;
        stalling_nxt   = stalling;
        scan_dir_nxt   = scan_dir;
        depth_nxt      = depth;
        scan_done_nxt  = 1'b0;
        scan_error_nxt = scan_error;

        case (state)
            IDLE: begin
                if (fwd_trigger || bwd_trigger) begin
                    scan_dir_nxt = bwd_trigger;
                    depth_nxt    = '0;
                    stalling_nxt = 1'b1;
                    state_nxt    = STEP;
                end
            end
            STEP: begin
                if (at_limit) begin
                    scan_error_nxt = 1'b1;
                    state_nxt      = ERR;
                end else begin
                    pc_step_nxt = scan_dir ? STEP_BWD : STEP_FWD;
                    state_nxt   = WAIT;
                end
            end
            WAIT: begin
                if (fetch_ready) begin
                    if (instruction == opener_of(scan_dir)) begin
                        if (depth == '1) begin
                            scan_error_nxt = 1'b1;
                            state_nxt      = ERR;
                        end else begin
                            depth_nxt = depth + DEPTH_WIDTH'(1);
                            state_nxt = STEP;
                        end
                    end else if (instruction == closer_of(scan_dir)) begin
                        if (depth == '0) begin
                            state_nxt = MATCH;
                        end else begin
                            depth_nxt = depth - DEPTH_WIDTH'(1);
                            state_nxt = STEP;
                        end
                    end else begin
                        state_nxt = STEP;
                    end
                end
            end
            MATCH: begin
                // Forward step in both directions lands just past the bracket.
                pc_step_nxt   = STEP_FWD;
                scan_done_nxt = 1'b1;
                stalling_nxt  = 1'b0;
                depth_nxt     = '0;
                state_nxt     = IDLE;
            end
            ERR: begin
                stalling_nxt   = 1'b1;
                scan_error_nxt = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc_step    <= STEP_NONE;
            stalling   <= 1'b0;
            scan_dir   <= 1'b0;
            depth      <= '0;
            scan_done  <= 1'b0;
            scan_error <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc_step    <= pc_step_nxt;
            stalling   <= stalling_nxt;
            scan_dir   <= scan_dir_nxt;
            depth      <= depth_nxt;
            scan_done  <= scan_done_nxt;
            scan_error <= scan_error_nxt;
        end
    end

endmodule

// File: tb/tb_loop_scan_sequencer.sv
// Self-checking bench for loop_scan_sequencer: fixed program vectors,
// hand-written corner sequences and randomized programs vs a bracket model.
module tb_loop_scan_sequencer;
    import loop_scan_sequencer_pkg::*;

    logic        clk;
    logic        rst_n;
    op_code      instruction;
    logic        instr_valid;
    logic        cell_zero;
    logic [15:0] pc_r;
    PC_STEP      pc_step;
    logic        stalling;
    logic        scan_dir;
    logic [7:0]  depth;
    logic        scan_done;
    logic        scan_error;

    loop_scan_sequencer #(.PC_WIDTH(16), .DEPTH_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction),
        .instr_valid(instr_valid), .cell_zero(cell_zero), .pc(pc_r),
        .pc_step(pc_step), .stalling(stalling), .scan_dir(scan_dir),
        .depth(depth), .scan_done(scan_done), .scan_error(scan_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;
    op_code mem [0:65535];
    int  fetch_lat = 0;
    int  fcnt = 0;
    bit  fetch_en = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic op_code ch2op(input byte c);
        case (c)
            "[": return LPO;
            "]": return LPC;
            "+": return INC;
            "-": return DEC;
            ">": return MVR;
            "<": return MVL;
            ".": return OUT;
            ",": return INP;
            default: return NOP;
        endcase
    endfunction

    task automatic load_prog(input logic [15:0] base, input string s);
        for (int i = 0; i < s.len(); i++) mem[base + 16'(i)] = ch2op(s[i]);
    endtask

    task automatic clear_prog(input logic [15:0] base, input int len);
        for (int i = 0; i < len; i++) mem[base + 16'(i)] = NOP;
    endtask

    // Models the PC unit and a fetch with fetch_lat extra cycles after a PC move.
    task automatic tick();
        PC_STEP s;
        s = pc_step;
        @(posedge clk);
        #1;
        if (s == STEP_FWD) pc_r = pc_r + 16'd1;
        else if (s == STEP_BWD) pc_r = pc_r - 16'd1;
        if (fetch_en) begin
            if (s != STEP_NONE) fcnt = fetch_lat;
            else if (fcnt > 0) fcnt--;
            instr_valid = (fcnt == 0);
            instruction = mem[pc_r];
            if (stalling) cell_zero = 1'($urandom);
        end
    endtask

    task automatic do_reset();
        fetch_en = 0;
        instr_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Reference: walk the program by bracket-counting arithmetic.
    task automatic ref_scan(input logic [15:0] start, input bit dir,
                            output logic [15:0] fpc, output bit err, output int maxd);
        logic [15:0] p;
        int d;
        p = start; d = 0; maxd = 0; err = 0; fpc = start;
        for (int n = 0; n < 70000; n++) begin
            if ((!dir && p == 16'hFFFF) || (dir && p == 16'h0000)) begin err = 1; return; end
            p = dir ? p - 16'd1 : p + 16'd1;
            if (mem[p] == (dir ? LPC : LPO)) begin
                if (d == 255) begin err = 1; return; end
                d++;
                if (d > maxd) maxd = d;
            end else if (mem[p] == (dir ? LPO : LPC)) begin
                if (d == 0) begin fpc = p + 16'd1; return; end
                d--;
            end
        end
        err = 1;
    endtask

    task automatic run_scan(input logic [15:0] start, input bit cz,
                            output logic [15:0] fpc, output bit err, output int dcnt,
                            output int maxd, output bit dir_seen, output bit timeout);
        pc_r = start; instruction = mem[start]; instr_valid = 1'b1;
        cell_zero = cz; fcnt = 0; fetch_en = 1;
        dcnt = 0; maxd = 0; err = 0; timeout = 1; dir_seen = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (c == 0) dir_seen = scan_dir;
            if (int'(depth) > maxd) maxd = int'(depth);
            if (scan_error) begin err = 1; timeout = 0; break; end
            if (scan_done) begin dcnt++; tick(); timeout = 0; break; end
        end
        fetch_en = 0;
        instr_valid = 1'b0;
        repeat (3) begin
            tick();
            if (scan_done) dcnt++;
        end
        fpc = pc_r;
    endtask

    typedef struct {
        string prog;
        int    base;
        int    start_off;
        bit    cz;
        int    exp_pc;
        bit    exp_err;
        int    exp_maxd;
        bit    exp_dir;
    } vec_t;

    vec_t vecs[8];
    logic [15:0] fpc, mpc;
    bit   err, merr, dsn, tmo, seen, ok;
    int   dcnt, maxd, mmaxd;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = NOP;
        vecs[0] = '{"[+]",    10, 0, 1'b1, 13, 1'b0, 0, 1'b0};
        vecs[1] = '{"[[-]+]", 20, 0, 1'b1, 26, 1'b0, 1, 1'b0};
        vecs[2] = '{"[-[+]]", 30, 5, 1'b0, 31, 1'b0, 1, 1'b1};
        vecs[3] = '{"[[[]]]", 40, 0, 1'b1, 46, 1'b0, 2, 1'b0};
        vecs[4] = '{"[]]",    50, 2, 1'b0, 0,  1'b1, 1, 1'b1};
        vecs[5] = '{"+]",     0,  1, 1'b0, 0,  1'b1, 0, 1'b1};
        vecs[6] = '{"[>[<]]", 60, 0, 1'b1, 66, 1'b0, 1, 1'b0};
        vecs[7] = '{"[.,]",   70, 3, 1'b0, 71, 1'b0, 0, 1'b1};

        instruction = NOP; instr_valid = 1'b0; cell_zero = 1'b0; pc_r = '0;
        rst_n = 1'b0;
        #1;
        chk("reset_pc_step", pc_step, STEP_NONE);
        chk("reset_stalling", stalling, 0);
        chk("reset_scan_dir", scan_dir, 0);
        chk("reset_depth", depth, 0);
        chk("reset_scan_done", scan_done, 0);
        chk("reset_scan_error", scan_error, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fixed program vectors.
        for (int v = 0; v < 8; v++) begin
            fetch_lat = v % 3;
            load_prog(16'(vecs[v].base), vecs[v].prog);
            run_scan(16'(vecs[v].base + vecs[v].start_off), vecs[v].cz,
                     fpc, err, dcnt, maxd, dsn, tmo);
            chk($sformatf("vec%0d_timeout", v), tmo, 0);
            chk($sformatf("vec%0d_error", v), err, vecs[v].exp_err);
            chk($sformatf("vec%0d_dir", v), dsn, vecs[v].exp_dir);
            chk($sformatf("vec%0d_maxdepth", v), maxd, vecs[v].exp_maxd);
            if (!vecs[v].exp_err) begin
                chk($sformatf("vec%0d_final_pc", v), fpc, vecs[v].exp_pc);
                chk($sformatf("vec%0d_done_pulses", v), dcnt, 1);
                chk($sformatf("vec%0d_stall_after", v), stalling, 0);
            end else begin
                chk($sformatf("vec%0d_done_pulses", v), dcnt, 0);
                do_reset();
            end
            clear_prog(16'(vecs[v].base), vecs[v].prog.len());
        end

        // Stall latency and step sequence of "[+]" with single-cycle fetch.
        fetch_lat = 0;
        load_prog(16'd0, "[+]");
        pc_r = 16'd0; instruction = mem[0]; instr_valid = 1'b1; cell_zero = 1'b1;
        fcnt = 0; fetch_en = 1;
        chk("lat_stall_before", stalling, 0);
        tick();
        chk("lat_stall_after_trigger", stalling, 1);
        chk("lat_no_step_yet", pc_step, STEP_NONE);
        tick();
        chk("lat_first_step_fwd", pc_step, STEP_FWD);
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (scan_done) begin
                seen = 1;
                chk("lat_done_pc", pc_r, 2);
                chk("lat_final_step", pc_step, STEP_FWD);
            end
        end
        chk("lat_done_seen", seen, 1);
        tick();
        fetch_en = 0; instr_valid = 1'b0;
        chk("lat_final_pc", pc_r, 3);
        chk("lat_stall_low", stalling, 0);
        clear_prog(16'd0, 3);

        // Fetch hold of 3 cycles in WAIT.
        fetch_lat = 3;
        load_prog(16'd100, "[++]");
        pc_r = 16'd100; instruction = mem[100]; instr_valid = 1'b1; cell_zero = 1'b1;
        fcnt = 0; fetch_en = 1;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (pc_step == STEP_FWD) seen = 1;
        end
        chk("hold_step_seen", seen, 1);
        tick();
        chk("hold_valid_low", instr_valid, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("hold_no_step_%0d", k), pc_step, STEP_NONE);
            chk($sformatf("hold_depth_%0d", k), depth, 0);
            chk($sformatf("hold_pc_%0d", k), pc_r, 101);
        end
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            tick();
            if (scan_done) seen = 1;
        end
        chk("hold_done_seen", seen, 1);
        tick();
        fetch_en = 0; instr_valid = 1'b0;
        chk("hold_final_pc", pc_r, 104);
        clear_prog(16'd100, 4);

        // Forward boundary error and terminal ERR.
        fetch_lat = 0;
        load_prog(16'hFFFE, "[+");
        run_scan(16'hFFFE, 1'b1, fpc, err, dcnt, maxd, dsn, tmo);
        chk("err_timeout", tmo, 0);
        chk("err_flag", err, 1);
        chk("err_done_pulses", dcnt, 0);
        ok = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!(scan_error && stalling && pc_step == STEP_NONE)) ok = 0;
        end
        chk("err_held_20", ok, 1);
        chk("err_pc_stuck", pc_r, 16'hFFFF);
        rst_n = 1'b0;
        #1;
        chk("err_reset_flag", scan_error, 0);
        chk("err_reset_stall", stalling, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_prog(16'hFFFE, 2);

        // Reset during WAIT at depth 2.
        fetch_lat = 1;
        load_prog(16'd200, "[[[+]]]");
        pc_r = 16'd200; instruction = mem[200]; instr_valid = 1'b1; cell_zero = 1'b1;
        fcnt = 0; fetch_en = 1;
        seen = 0; ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            tick();
            if (depth == 8'd2 && pc_step == STEP_FWD) seen = 1;
            else if (seen && depth == 8'd2 && pc_step == STEP_NONE) ok = 1;
        end
        chk("rst_reached_depth2", ok, 1);
        fetch_en = 0; instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_depth", depth, 0);
        chk("rst_mid_stall", stalling, 0);
        chk("rst_mid_step", pc_step, STEP_NONE);
        chk("rst_mid_dir", scan_dir, 0);
        chk("rst_mid_done_err", {scan_done, scan_error}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mpc = pc_r; ok = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (pc_step != STEP_NONE || stalling) ok = 0;
        end
        chk("rst_no_steps_after", ok, 1);
        chk("rst_pc_unmoved", pc_r, mpc);
        clear_prog(16'd200, 7);
        load_prog(16'd300, "[+]");
        run_scan(16'd300, 1'b1, fpc, err, dcnt, maxd, dsn, tmo);
        chk("rst_rescan_pc", fpc, 303);
        chk("rst_rescan_depth", maxd, 0);
        chk("rst_rescan_err", err, 0);
        clear_prog(16'd300, 3);

        // Randomized programs vs the bracket model.
        for (int it = 0; it < 40; it++) begin
            bit d;
            logic [15:0] base, st;
            int idx;
            d = 1'($urandom_range(0, 1));
            base = d ? 16'h0000 : 16'hFFE0;
            for (int i = 0; i < 32; i++) begin
                case ($urandom_range(0, 7))
                    0, 1: mem[base + 16'(i)] = LPO;
                    2, 3: mem[base + 16'(i)] = LPC;
                    4: mem[base + 16'(i)] = INC;
                    5: mem[base + 16'(i)] = DEC;
                    6: mem[base + 16'(i)] = MVR;
                    default: mem[base + 16'(i)] = NOP;
                endcase
            end
            idx = $urandom_range(0, 31);
            st = base + 16'(idx);
            mem[st] = d ? LPC : LPO;
            fetch_lat = $urandom_range(0, 3);
            ref_scan(st, d, mpc, merr, mmaxd);
            run_scan(st, !d, fpc, err, dcnt, maxd, dsn, tmo);
            chk($sformatf("rnd%0d_timeout", it), tmo, 0);
            chk($sformatf("rnd%0d_error", it), err, merr);
            chk($sformatf("rnd%0d_maxdepth", it), maxd, mmaxd);
            if (!merr) begin
                chk($sformatf("rnd%0d_final_pc", it), fpc, mpc);
                chk($sformatf("rnd%0d_done_pulses", it), dcnt, 1);
            end
            if (err || merr) do_reset();
            clear_prog(base, 32);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
